rr_grant_arbiter: RTL and testbench

Round-robin arbiter sharing one resource between 8 requesters. It issues one grant at a time and holds it until the owner releases, drops its request or exceeds a hold limit. Output is the binary owner index plus enable, and the one-hot grant produced by the existing 3-to-8 `decoder` module. It sits between request sources and the shared resource's select/enable logic.

---
 rtl/rr_grant_arbiter_pkg.sv | 16 +
 rtl/rr_grant_arbiter_decoder.sv | 17 +
 rtl/rr_grant_arbiter.sv | 112 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin grant arbiter.
package rr_grant_arbiter_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_decoder.sv
// Legacy 3-to-8 enable decoder: asserts Y[7 - {I[0],I[1],I[2]}] when EN is high.
module decoder (
  input  logic [2:0] I,
  input  logic       EN,
  output logic [7:0] Y
);

  logic [2:0] sel;

  assign sel = 3'd7 - {I[0], I[1], I[2]};

  always_comb begin
    Y = '0;
    if (EN) Y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters: one grant at a time, held until done,
// request drop or hold limit, with at least one idle cycle between grants.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_W   = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_en,
  output logic                 timeout
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic              HOLD_ON    = (MAX_HOLD != 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [HOLD_W-1:0]  hold_inc;
  logic               hold_hit;
  logic               release_now;
  logic [IDX_W-1:0]   dec_sel;

  // Rotating priority search starting at ptr, wrapping 7 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // The limit is compared against the incremented count so a grant lasts MAX_HOLD cycles.
  always_comb begin
    hold_inc    = (hold_q == MAX_HOLD_C) ? hold_q : hold_q + 1'b1;
    hold_hit    = HOLD_ON && (hold_inc == MAX_HOLD_C);
    release_now = done || !req[owner_q] || hold_hit;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        hold_d = hold_inc;
        if (release_now) begin
          state_d   = ST_IDLE;
          ptr_d     = owner_q + 1'b1;
          timeout_d = hold_hit && !done && req[owner_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_idx = owner_q;
  assign gnt_en  = (state_q == ST_GRANT);
  assign timeout = timeout_q;

  // The decoder's index is reversed and inverted; pre-compensate so gnt[owner] is set.
  assign dec_sel = bitrev3(3'd7 - owner_q);

  decoder u_decoder (
    .I  (dec_sel),
    .EN (gnt_en),
    .Y  (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: default-limit instance (a) and MAX_HOLD=3 instance (b).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic       done_a, done_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_en_a, gnt_en_b;
  logic       timeout_a, timeout_b;

  logic [12:0] got_a, got_b, exp;
  int unsigned n_cmp;
  int unsigned n_bad;

  rr_grant_arbiter #(.HOLD_W(4), .MAX_HOLD(15)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req_a),
    .done    (done_a),
    .gnt     (gnt_a),
    .gnt_idx (gnt_idx_a),
    .gnt_en  (gnt_en_a),
    .timeout (timeout_a)
  );

  rr_grant_arbiter #(.HOLD_W(4), .MAX_HOLD(3)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req_b),
    .done    (done_b),
    .gnt     (gnt_b),
    .gnt_idx (gnt_idx_b),
    .gnt_en  (gnt_en_b),
    .timeout (timeout_b)
  );

  // Observed tuple: {gnt_en, gnt_idx, gnt, timeout}
  assign got_a = {gnt_en_a, gnt_idx_a, gnt_a, timeout_a};
  assign got_b = {gnt_en_b, gnt_idx_b, gnt_b, timeout_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
    tick(); tick();
    exp = {1'b0, 3'd0, 8'h00, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL reset_a: got %h want %h", got_a, exp); end
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL reset_b: got %h want %h", got_b, exp); end
    rst = 1'b0; req_a = 8'h28;
    tick();
    exp = {1'b1, 3'd3, 8'h08, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL reset_first_grant: got %h want %h", got_a, exp); end
    #3 rst = 1'b1;
    #1;
    exp = {1'b0, 3'd0, 8'h00, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL reset_async: got %h want %h", got_a, exp); end
    tick();
    rst = 1'b0;
    tick();
    exp = {1'b1, 3'd3, 8'h08, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL reset_regrant: got %h want %h", got_a, exp); end
    done_a = 1'b1; tick(); done_a = 1'b0; req_a = '0; tick();
  endtask

  task automatic test_single();
    req_a = 8'h10;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp = {1'b1, 3'd4, 8'h10, 1'b0};
      n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL single_c%0d: got %h want %h", c, got_a, exp); end
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    exp = {1'b0, 3'd4, 8'h00, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL single_c5: got %h want %h", got_a, exp); end
    tick();
    exp = {1'b1, 3'd4, 8'h10, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL single_c6: got %h want %h", got_a, exp); end
    req_a = '0;
    tick();
    exp = {1'b0, 3'd4, 8'h00, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL drop_release: got %h want %h", got_a, exp); end
    done_a = 1'b1; req_a = 8'h01;
    tick();
    done_a = 1'b0;
    exp = {1'b1, 3'd0, 8'h01, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL idle_done_ignored: got %h want %h", got_a, exp); end
    done_a = 1'b1; tick(); done_a = 1'b0; req_a = '0; tick();
  endtask

  task automatic test_rotation();
    logic [2:0] e_idx;
    logic [7:0] e_gnt;
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 8'hFF;
    for (int unsigned k = 0; k <= 8; k++) begin
      e_idx = 3'(k % 8);
      e_gnt = 8'h01 << e_idx;
      tick();
      exp = {1'b1, e_idx, e_gnt, 1'b0};
      n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL rot_grant%0d: got %h want %h", k, got_a, exp); end
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      exp = {1'b0, e_idx, 8'h00, 1'b0};
      n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL rot_idle%0d: got %h want %h", k, got_a, exp); end
    end
    req_a = '0;
    tick();
  endtask

  task automatic test_wrap();
    req_a = 8'h20;
    tick();
    exp = {1'b1, 3'd5, 8'h20, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL wrap_own5: got %h want %h", got_a, exp); end
    done_a = 1'b1; tick(); done_a = 1'b0;
    req_a = 8'h03;
    tick();
    exp = {1'b1, 3'd0, 8'h01, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL wrap_own0: got %h want %h", got_a, exp); end
    done_a = 1'b1; tick(); done_a = 1'b0;
    tick();
    exp = {1'b1, 3'd1, 8'h02, 1'b0};
    n_cmp++; if (got_a !== exp) begin n_bad++; $display("FAIL wrap_own1: got %h want %h", got_a, exp); end
    done_a = 1'b1; tick(); done_a = 1'b0; req_a = '0; tick();
  endtask

  task automatic test_timeout();
    req_b = 8'h04;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = {1'b1, 3'd2, 8'h04, 1'b0};
      n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_hold_c%0d: got %h want %h", c, got_b, exp); end
    end
    tick();
    exp = {1'b0, 3'd2, 8'h00, 1'b1};
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_pulse: got %h want %h", got_b, exp); end
    tick();
    exp = {1'b1, 3'd2, 8'h04, 1'b0};
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_regrant: got %h want %h", got_b, exp); end
    tick(); tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    exp = {1'b0, 3'd2, 8'h00, 1'b0};
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_collision: got %h want %h", got_b, exp); end
    req_b = 8'h08;
    tick();
    exp = {1'b1, 3'd3, 8'h08, 1'b0};
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_next_grant: got %h want %h", got_b, exp); end
    req_b = '0;
    tick();
    exp = {1'b0, 3'd3, 8'h00, 1'b0};
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_drop: got %h want %h", got_b, exp); end
    tick();
    n_cmp++; if (got_b !== exp) begin n_bad++; $display("FAIL tmo_stay_idle: got %h want %h", got_b, exp); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
